// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot view pipeline: frame geometry, coordinate
// widths, the default view centre and the coordinate generator's frame FSM states.
package mandel_pkg;

   localparam int COORD_WIDTH = 16;
   localparam int ZOOM_WIDTH  = 8;
   localparam int H_ACTIVE    = 640;
   localparam int V_ACTIVE    = 480;

   // Q4.12: -1.0 on the real axis, centred vertically
   localparam logic signed [COORD_WIDTH-1:0] DEFAULT_CENTRE_X = -16'sd4096;
   localparam logic signed [COORD_WIDTH-1:0] DEFAULT_CENTRE_Y = 16'sd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SNAP,
      ST_INIT,
      ST_RUN
   } coord_state_t;

endpackage

// File: rtl/coord_axis_acc.sv
// One axis of the pixel coordinate accumulator: a signed Q4.(12+FRAC_EXT) register
// with load, pre-sample add and post-sample advance, presenting the floor-truncated Q4.12 value.
module coord_axis_acc #(
   parameter int COORD_WIDTH = 16,
   parameter int FRAC_EXT    = 8
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     load,
   input  logic signed [COORD_WIDTH+FRAC_EXT-1:0]   load_value,
   input  logic                                     add,
   input  logic                                     advance,
   input  logic signed [COORD_WIDTH+FRAC_EXT-1:0]   step,
   output logic signed [COORD_WIDTH-1:0]            coord
);

   localparam int ACC_W = COORD_WIDTH + FRAC_EXT;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] cur;

   // cur is the value a pixel sampled this cycle sees; advance steps past it afterwards
   always_comb begin
      cur = acc;
      if (load) begin
         cur = load_value;
      end else if (add) begin
         cur = acc + step;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (load || add || advance) begin
         acc <= advance ? cur + step : cur;
      end
   end

   assign coord = cur[ACC_W-1:FRAC_EXT];

endmodule

// File: rtl/pixel_coord_gen.sv
// Per-pixel complex coordinate generator: snapshots the view parameters once per
// frame and walks c across the screen with add-only stepping.
module pixel_coord_gen #(
   parameter int COORD_WIDTH = mandel_pkg::COORD_WIDTH,
   parameter int ZOOM_WIDTH  = mandel_pkg::ZOOM_WIDTH,
   parameter int FRAC_EXT    = 8,
   parameter int H_ACTIVE    = mandel_pkg::H_ACTIVE,
   parameter int V_ACTIVE    = mandel_pkg::V_ACTIVE,
   parameter int STEP_SHIFT  = 12
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          frame_start,
   input  logic                          line_start,
   input  logic                          pixel_advance,
   input  logic signed [COORD_WIDTH-1:0] centre_x,
   input  logic signed [COORD_WIDTH-1:0] centre_y,
   input  logic [ZOOM_WIDTH-1:0]         zoom_level,
   output logic signed [COORD_WIDTH-1:0] c_re,
   output logic signed [COORD_WIDTH-1:0] c_im,
   output logic                          c_valid
);

   import mandel_pkg::*;

   localparam int ACC_W = COORD_WIDTH + FRAC_EXT;

   typedef logic signed [ACC_W-1:0] acc_t;

   coord_state_t                  state;
   coord_state_t                  state_nxt;
   logic signed [COORD_WIDTH-1:0] snap_cx;
   logic signed [COORD_WIDTH-1:0] snap_cy;
   logic [ZOOM_WIDTH-1:0]         snap_zoom;
   acc_t                          step;
   acc_t                          left_edge;
   logic                          first_line;
   acc_t                          step_calc;
   acc_t                          left_calc;
   acc_t                          im_calc;
   logic                          init_en;
   logic                          line_ok;
   logic                          pix_ok;
   logic                          im_line_add;
   logic signed [COORD_WIDTH-1:0] re_coord;
   logic signed [COORD_WIDTH-1:0] im_coord;
   logic signed [COORD_WIDTH-1:0] c_re_p1;
   logic signed [COORD_WIDTH-1:0] c_im_p1;
   logic                          vld_p1;

   // Deeper zooms clamp so the step never shrinks below one accumulator LSB
   function automatic acc_t zoom_step(input logic [ZOOM_WIDTH-1:0] z);
      acc_t base;
      int   sh;
      sh   = (int'(z) > STEP_SHIFT) ? STEP_SHIFT : int'(z);
      base = '0;
      base[STEP_SHIFT] = 1'b1;
      return base >> sh;
   endfunction

   function automatic acc_t widen(input logic signed [COORD_WIDTH-1:0] v);
      return acc_t'({v, {FRAC_EXT{1'b0}}});
   endfunction

   function automatic acc_t half_span(input acc_t s, input int n);
      return s * acc_t'(n / 2);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (frame_start) begin
         state_nxt = ST_SNAP;
      end else begin
         case (state)
            ST_SNAP: state_nxt = ST_INIT;
            ST_INIT: state_nxt = ST_RUN;
            default: state_nxt = state;
         endcase
      end
   end

   assign init_en     = (state == ST_INIT) && !frame_start;
   assign line_ok     = (state == ST_RUN) && !frame_start && line_start;
   assign pix_ok      = (state == ST_RUN) && !frame_start && pixel_advance;
   assign im_line_add = line_ok && !first_line;

   assign step_calc = zoom_step(snap_zoom);
   assign left_calc = widen(snap_cx) - half_span(step_calc, H_ACTIVE);
   assign im_calc   = widen(snap_cy) - half_span(step_calc, V_ACTIVE);

   // Frame setup: SNAP captures the freshly updated view, INIT derives step and edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_cx    <= '0;
         snap_cy    <= '0;
         snap_zoom  <= '0;
         step       <= '0;
         left_edge  <= '0;
         first_line <= 1'b0;
      end else begin
         if (state == ST_SNAP) begin
            snap_cx   <= centre_x;
            snap_cy   <= centre_y;
            snap_zoom <= zoom_level;
         end
         if (init_en) begin
            step       <= step_calc;
            left_edge  <= left_calc;
            first_line <= 1'b1;
         end else if (line_ok) begin
            first_line <= 1'b0;
         end
      end
   end

   coord_axis_acc #(
      .COORD_WIDTH (COORD_WIDTH),
      .FRAC_EXT    (FRAC_EXT)
   ) u_re_acc (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (line_ok),
      .load_value (left_edge),
      .add        (1'b0),
      .advance    (pix_ok),
      .step       (step),
      .coord      (re_coord)
   );

   coord_axis_acc #(
      .COORD_WIDTH (COORD_WIDTH),
      .FRAC_EXT    (FRAC_EXT)
   ) u_im_acc (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (init_en),
      .load_value (im_calc),
      .add        (im_line_add),
      .advance    (1'b0),
      .step       (step),
      .coord      (im_coord)
   );

   // Output stage: one cycle after the accepted pixel_advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_re_p1 <= '0;
         c_im_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= pix_ok;
         if (pix_ok) begin
            c_re_p1 <= re_coord;
            c_im_p1 <= im_coord;
         end
      end
   end

   assign c_re    = c_re_p1;
   assign c_im    = c_im_p1;
   assign c_valid = vld_p1;

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Directed bench for pixel_coord_gen: default view, zoom clamping, event collisions
// and mid-line reset, with hand-computed Q4.12 expectations.
module tb_pixel_coord_gen;

   import mandel_pkg::*;

   logic                          clk           = 1'b0;
   logic                          rst_n         = 1'b0;
   logic                          frame_start   = 1'b0;
   logic                          line_start    = 1'b0;
   logic                          pixel_advance = 1'b0;
   logic signed [COORD_WIDTH-1:0] centre_x      = '0;
   logic signed [COORD_WIDTH-1:0] centre_y      = '0;
   logic [ZOOM_WIDTH-1:0]         zoom_level    = '0;
   logic signed [COORD_WIDTH-1:0] c_re;
   logic signed [COORD_WIDTH-1:0] c_im;
   logic                          c_valid;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pixel_coord_gen dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_start   (frame_start),
      .line_start    (line_start),
      .pixel_advance (pixel_advance),
      .centre_x      (centre_x),
      .centre_y      (centre_y),
      .zoom_level    (zoom_level),
      .c_re          (c_re),
      .c_im          (c_im),
      .c_valid       (c_valid)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Decoy view values sit on the input during frame_start; the real ones follow a cycle later
   task automatic start_frame(input logic signed [COORD_WIDTH-1:0] cx,
                              input logic signed [COORD_WIDTH-1:0] cy,
                              input logic [ZOOM_WIDTH-1:0] z);
      frame_start = 1'b1;
      centre_x    = 16'sh3000;
      centre_y    = -16'sh2000;
      zoom_level  = 8'd9;
      tick();
      frame_start = 1'b0;
      centre_x    = cx;
      centre_y    = cy;
      zoom_level  = z;
      tick();
      tick();
   endtask

   task automatic new_line();
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic pixel(input string tag, input int exp_re, input int exp_im);
      pixel_advance = 1'b1;
      tick();
      pixel_advance = 1'b0;
      check({tag, "_valid"}, c_valid, 1);
      check({tag, "_re"}, c_re, exp_re);
      check({tag, "_im"}, c_im, exp_im);
   endtask

   // Zoom 0 around (-1.0, 0): 16 Q4.12 LSBs per pixel, 640x480 grid
   task automatic default_frame(input string tag);
      start_frame(DEFAULT_CENTRE_X, DEFAULT_CENTRE_Y, 8'd0);
      new_line();
      check({tag, "_no_valid_before_px"}, c_valid, 0);
      pixel_advance = 1'b1;
      for (int i = 0; i < H_ACTIVE; i++) begin
         tick();
         check({tag, "_l0_valid"}, c_valid, 1);
         check({tag, "_l0_re"}, c_re, -9216 + 16 * i);
         if (i == 0) begin
            check({tag, "_px0_hex_re"}, c_re, 16'shDC00);
            check({tag, "_px0_hex_im"}, c_im, 16'shF100);
         end
      end
      pixel_advance = 1'b0;
      check({tag, "_px639_re"}, c_re, 1008);
      check({tag, "_l0_im"}, c_im, -3840);
      tick();
      check({tag, "_valid_drops"}, c_valid, 0);
      check({tag, "_re_holds"}, c_re, 1008);
      for (int l = 1; l < V_ACTIVE; l++) begin
         new_line();
         pixel({tag, "_line_px0"}, -9216, -3840 + 16 * l);
      end
      check({tag, "_last_im"}, c_im, 3824);
   endtask

   initial begin
      pixel_advance = 1'b1;
      #12;
      check("reset_re", c_re, 0);
      check("reset_im", c_im, 0);
      check("reset_valid", c_valid, 0);
      rst_n = 1'b1;
      tick();
      check("idle_ignores_pixel", c_valid, 0);
      pixel_advance = 1'b0;

      default_frame("first");

      // zoom 3: step 512 acc LSBs (2 Q4.12 LSBs per pixel)
      start_frame(DEFAULT_CENTRE_X, 16'sd0, 8'd3);
      new_line();
      pixel("z3_px0", -4736, -480);
      pixel("z3_px1", -4734, -480);

      // zoom 14 clamps to step 1; the left edge floors from -4097.25
      start_frame(DEFAULT_CENTRE_X, 16'sd0, 8'd14);
      new_line();
      pixel("z14_px0", -4098, -1);
      pixel("z14_px1", -4098, -1);

      // frame_start beats pixel_advance, and only the T+1 view values count
      frame_start   = 1'b1;
      pixel_advance = 1'b1;
      centre_x      = 16'sh2000;
      centre_y      = 16'sh0000;
      zoom_level    = 8'd5;
      tick();
      check("fs_beats_pixel", c_valid, 0);
      frame_start   = 1'b0;
      pixel_advance = 1'b0;
      centre_x      = 16'sh0000;
      centre_y      = 16'sh0800;
      zoom_level    = 8'd1;
      tick();
      check("snap_no_valid", c_valid, 0);
      tick();

      // zoom 1: 8 Q4.12 LSBs per pixel; left edge -2560, first line im 128
      line_start    = 1'b1;
      pixel_advance = 1'b1;
      tick();
      line_start    = 1'b0;
      pixel_advance = 1'b0;
      check("lp_valid", c_valid, 1);
      check("lp_re", c_re, -2560);
      check("lp_im", c_im, 128);
      pixel("lp_next", -2552, 128);
      line_start    = 1'b1;
      pixel_advance = 1'b1;
      tick();
      line_start    = 1'b0;
      pixel_advance = 1'b0;
      check("lp2_valid", c_valid, 1);
      check("lp2_re", c_re, -2560);
      check("lp2_im", c_im, 136);
      pixel("lp2_next", -2552, 136);

      // asynchronous reset in the middle of a line
      start_frame(DEFAULT_CENTRE_X, DEFAULT_CENTRE_Y, 8'd0);
      new_line();
      pixel("mid_px0", -9216, -3840);
      pixel("mid_px1", -9200, -3840);
      pixel_advance = 1'b1;
      tick();
      check("mid_px2_valid", c_valid, 1);
      check("mid_px2_re", c_re, -9184);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_re", c_re, 0);
      check("rst_async_im", c_im, 0);
      check("rst_async_valid", c_valid, 0);
      tick();
      check("rst_held_valid", c_valid, 0);
      #3;
      rst_n = 1'b1;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      check("post_rst_no_valid", c_valid, 0);
      tick();
      check("post_rst_still_no_valid", c_valid, 0);
      check("post_rst_re_zero", c_re, 0);
      pixel_advance = 1'b0;

      default_frame("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
